// File: rtl/dly_tdc_reader.sv
// Delay-line TDC reader: launches an edge into an inverter chain, samples the taps NAVG times and reports the averaged stage count.
// Latency: NAVG*(3+RCV) cycles from the START edge to VALID; one LAUNCH pulse per run, RCV quiet cycles between runs.
// Backpressure: RESULT/SAT/VALID hold in DONE until READY; START is only looked at in IDLE.
module dly_tdc_reader #(
    parameter  int NTAP     = 32,
    parameter  int AVG_LOG2 = 2,
    parameter  int RCV      = 4,
    localparam int OUTW     = $clog2(NTAP + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [NTAP-1:0] tap,
    output logic            launch,
    output logic            busy,
    output logic [OUTW-1:0] result,
    output logic            sat,
    output logic            valid,
    input  logic            ready
);

    // Accumulator holds NAVG sums of at most NTAP each, so OUTW+AVG_LOG2 bits never wrap.
    localparam int ACCW = OUTW + AVG_LOG2;
    localparam int NAVG = 1 << AVG_LOG2;
    localparam int RUNW = AVG_LOG2 + 1;
    localparam int RCVW = $clog2(RCV + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_SYNC    = 3'd2,
        S_ACCUM   = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Odd inverters idle high and even inverters idle low when the chain input is low;
    // this mask flips the tap polarity so a resting chain reads as all zeros.
    function automatic logic [NTAP-1:0] rest_mask();
        logic [NTAP-1:0] m;
        for (int i = 0; i < NTAP; i++) begin
            m[i] = ((i % 2) == 0);
        end
        return m;
    endfunction

    localparam logic [NTAP-1:0] REST = rest_mask();

    // Counting ones rather than searching for the first zero keeps bubbles in the
    // thermometer code from producing large errors.
    function automatic logic [OUTW-1:0] popcnt(input logic [NTAP-1:0] v);
        logic [OUTW-1:0] c;
        c = '0;
        for (int i = 0; i < NTAP; i++) begin
            c = c + OUTW'(v[i]);
        end
        return c;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [NTAP-1:0]   norm;
    logic [NTAP-1:0]   stage1;
    logic [NTAP-1:0]   stage2;
    logic [OUTW-1:0]   pop;
    logic [ACCW-1:0]   acc;
    logic [RUNW-1:0]   run_cnt;
    logic [RCVW-1:0]   rcv_cnt;
    logic              sat_acc;
    logic              rcv_last;
    logic              take_start;
    logic              done_entry;

    // Polarity-corrected taps and the stage count of the synchronised sample.
    always_comb begin
        norm = tap ^ REST;
        pop  = popcnt(stage2);
    end

    // Shared decode terms used by both the FSM and the datapath.
    always_comb begin
        rcv_last   = (state == S_RECOVER) && (rcv_cnt == RCVW'(RCV - 1));
        take_start = (state == S_IDLE) && start;
        done_entry = rcv_last && (run_cnt == RUNW'(NAVG));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one pass LAUNCH->SYNC->ACCUM->RECOVER per run, DONE after NAVG runs.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH:  state_nxt = S_SYNC;
            S_SYNC:    state_nxt = S_ACCUM;
            S_ACCUM:   state_nxt = S_RECOVER;
            S_RECOVER: begin
                if (rcv_last) begin
                    state_nxt = (run_cnt == RUNW'(NAVG)) ? S_DONE : S_LAUNCH;
                end
            end
            S_DONE: begin
                if (ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // BUSY is a pure state decode; reset drives the state to IDLE so it drops at once.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // LAUNCH comes straight from a flop so the chain input never sees decode glitches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            launch <= 1'b0;
        end else begin
            launch <= (state_nxt == S_LAUNCH);
        end
    end

    // Two-flop capture of the asynchronous taps: sample at the end of LAUNCH, retime in SYNC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage1 <= '0;
            stage2 <= '0;
        end else begin
            if (state == S_LAUNCH) begin
                stage1 <= norm;
            end
            if (state == S_SYNC) begin
                stage2 <= stage1;
            end
        end
    end

    // Per-measurement accumulation of stage counts, run count and saturation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            run_cnt <= '0;
            sat_acc <= 1'b0;
        end else if (take_start) begin
            acc     <= '0;
            run_cnt <= '0;
            sat_acc <= 1'b0;
        end else if (state == S_ACCUM) begin
            acc     <= acc + ACCW'(pop);
            run_cnt <= run_cnt + RUNW'(1);
            if (pop == OUTW'(NTAP)) begin
                sat_acc <= 1'b1;
            end
        end
    end

    // Recovery timer: cleared while accumulating, counts through the RCV quiet cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcv_cnt <= '0;
        end else if (state == S_ACCUM) begin
            rcv_cnt <= '0;
        end else if (state == S_RECOVER) begin
            rcv_cnt <= rcv_cnt + RCVW'(1);
        end
    end

    // Output registers: loaded only on DONE entry so IDLE keeps the previous measurement.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result <= '0;
            sat    <= 1'b0;
            valid  <= 1'b0;
        end else if (done_entry) begin
            result <= OUTW'(acc >> AVG_LOG2);
            sat    <= sat_acc;
            valid  <= 1'b1;
        end else if ((state == S_DONE) && ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: doc/dly_tdc_reader.md
DLY_TDC_READER -- requirements
Module: dly_tdc_reader

Interface
REQ-001 The module SHALL have parameter NTAP, default 32, giving the number of inverter-chain taps read (NTAP >= 2).
REQ-002 The module SHALL have parameter AVG_LOG2, default 2, giving the number of runs averaged per result as NAVG = 2^AVG_LOG2 (0..4).
REQ-003 The module SHALL have parameter RCV, default 4, giving the recovery cycles with LAUNCH low between runs (RCV >= 1).
REQ-004 The module SHALL have local width OUTW = clog2(NTAP+1).
REQ-005 The module SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port RSTN, input, 1 bit, the asynchronous active-low reset.
REQ-007 The module SHALL have port START, input, 1 bit, the measurement request, sampled only in IDLE.
REQ-008 The module SHALL have port TAP, input, NTAP bits, the raw delay-chain outputs, where TAP[k] is the output of inverter k+1 and is asynchronous to CLK.
REQ-009 The module SHALL have port LAUNCH, output, 1 bit, driving the input of the first chain inverter.
REQ-010 The module SHALL have port BUSY, output, 1 bit, high in every state except IDLE.
REQ-011 The module SHALL have port RESULT, output, OUTW bits, the averaged count of stages traversed in one CLK period.
REQ-012 The module SHALL have port SAT, output, 1 bit, high when any run in the measurement saw the edge pass the whole chain.
REQ-013 The module SHALL have port VALID, output, 1 bit, qualifying RESULT and SAT.
REQ-014 The module SHALL have port READY, input, 1 bit, the consumer acceptance signal.

Function
REQ-015 The block SHALL normalise taps as N[k] = TAP[k] XOR (k even), so that with LAUNCH low the chain at rest gives N = 0.
REQ-016 The FSM SHALL have states IDLE, LAUNCH, SYNC, ACCUM, RECOVER and DONE.
REQ-017 In IDLE with START=1, the block SHALL clear the accumulator, run counter and SAT, and go to LAUNCH; START in any other state SHALL be ignored.
REQ-018 In LAUNCH, the block SHALL drive LAUNCH=1 for exactly one cycle, capture N into stage-1 flops at the end of that cycle, and go to SYNC.
REQ-019 In SYNC, the block SHALL copy stage-1 into stage-2 flops as a metastability stage and go to ACCUM; LAUNCH SHALL be 0 in all states except LAUNCH.
REQ-020 In ACCUM, the block SHALL add popcount(stage-2), range 0..NTAP and bubble-tolerant, to an accumulator of OUTW+AVG_LOG2 bits that cannot overflow, set SAT if popcount = NTAP, and go to RECOVER.
REQ-021 RECOVER SHALL last exactly RCV cycles, then go to LAUNCH if fewer than NAVG runs are complete, else to DONE.
REQ-022 On entry to DONE, RESULT SHALL equal accumulator >> AVG_LOG2 (truncating) and VALID SHALL be 1.
REQ-023 With START sampled at edge t0, VALID SHALL rise at edge t0 + NAVG*(3+RCV).
REQ-024 In DONE, RESULT, SAT and VALID SHALL hold stable until READY=1; on a cycle with VALID=1 and READY=1 the block SHALL return to IDLE with VALID=0.
REQ-025 READY asserted outside DONE SHALL have no effect.
REQ-026 RESULT and SAT SHALL retain their last value in IDLE, and the old value SHALL be overwritten only on the next DONE entry.
REQ-027 START=1 in the same cycle as the DONE handshake SHALL be ignored, because the block is not in IDLE; the request is taken on a later IDLE cycle.

Reset
REQ-028 RSTN=0 SHALL asynchronously force state IDLE, LAUNCH=0, BUSY=0, VALID=0, RESULT=0, SAT=0, and clear the accumulator, run counter, RECOVER counter and both tap stages.
REQ-029 Reset asserted mid-measurement SHALL abort it with no VALID pulse, and LAUNCH SHALL fall immediately.
REQ-030 Release of RSTN SHALL take effect at the next CLK edge, and the first START is honoured no earlier than that edge.

Verification
REQ-031 Bench: defaults, TAP model where normalized ones = 10 after LAUNCH, START pulse at t0 -> VALID rises at t0+28, RESULT=10, SAT=0, four 1-cycle LAUNCH pulses spaced 7 cycles apart.
REQ-032 Bench: per-run counts 9,10,10,11 -> accumulator 40, RESULT=10; counts 9,9,9,10 -> RESULT=9 (truncation).
REQ-033 Bench: one run with all NTAP normalized bits set -> SAT=1 and RESULT reflects average including 32.
REQ-034 Bench: READY held low 20 cycles in DONE -> RESULT, SAT and VALID stable; READY=1 -> IDLE next edge, BUSY=0; START during BUSY -> ignored, no extra LAUNCH.
REQ-035 Bench: RSTN pulsed low during the third RECOVER -> LAUNCH=0 and VALID=0 at once, all outputs 0, no VALID afterwards until a new START.
REQ-036 Bench: bubble pattern with normalized ones at 0..7 and 9 -> count 9; raw TAP at rest = alternating 1010... from bit 0 -> count 0.
